// File: rtl/pad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pad_pkg : shared constants and state encoding for pad_debounce       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pad_pkg;

  localparam int N_PAD_DEFAULT   = 3;
  localparam int DB_CYCLES_BOARD = 500000;
  localparam int DB_CYCLES_SIM   = 4;

  typedef enum logic [1:0] {
    ST_LOW  = 2'b00,
    ST_RISE = 2'b01,
    ST_HIGH = 2'b10,
    ST_FALL = 2'b11
  } pad_state_e;

endpackage
`default_nettype wire

// File: rtl/pad_debounce_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pad_debounce_ch : one pad channel, sync + stability FSM + pulses     |
// | Optional auto-repeat: PAD_DEBOUNCE_AUTO_REPEAT_EN                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pad_debounce_ch
  import pad_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_BOARD
`ifdef PAD_DEBOUNCE_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_raw,
  output logic pad_level,
  output logic pad_press,
  output logic pad_release,
  output logic press_next
);

  localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q;
  logic             s2_q;
  pad_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             rpt_fire;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = rpt_fire;
    release_d = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (s2_q) begin
          state_d = ST_RISE;
          cnt_d   = CNT_ONE;
        end
      end
      ST_RISE: begin
        if (!s2_q) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s2_q) begin
          state_d = ST_FALL;
          cnt_d   = CNT_ONE;
        end
      end
      ST_FALL: begin
        if (s2_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_LOW;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef PAD_DEBOUNCE_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;

  // Down-counter: loaded on accept, runs only while HIGH sees a high pad.
  always_comb begin
    rpt_d    = rpt_q;
    rpt_fire = 1'b0;
    case (state_q)
      ST_RISE: if (s2_q && (cnt_q == CNT_LAST)) rpt_d = RPT_W'(REPEAT_DELAY - 1);
      ST_HIGH: begin
        if (s2_q) begin
          if (rpt_q == '0) begin
            rpt_fire = 1'b1;
            rpt_d    = RPT_W'(REPEAT_PERIOD - 1);
          end else begin
            rpt_d = rpt_q - RPT_W'(1);
          end
        end
      end
      ST_FALL: if (!s2_q && (cnt_q == CNT_LAST)) rpt_d = '0;
      default: rpt_d = rpt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) rpt_q <= '0;
    else     rpt_q <= rpt_d;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= ST_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= pad_raw;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign pad_level   = level_q;
  assign pad_press   = press_q;
  assign pad_release = release_q;
  assign press_next  = press_d;

endmodule
`default_nettype wire

// File: rtl/pad_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pad_debounce : N_PAD independent debounce channels plus any_press    |
// | Optional auto-repeat: PAD_DEBOUNCE_AUTO_REPEAT_EN                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pad_debounce
  import pad_pkg::*;
#(
  parameter int N_PAD     = N_PAD_DEFAULT,
  parameter int DB_CYCLES = DB_CYCLES_BOARD
`ifdef PAD_DEBOUNCE_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:N_PAD-1] pad_raw,
  output logic [0:N_PAD-1] pad_level,
  output logic [0:N_PAD-1] pad_press,
  output logic [0:N_PAD-1] pad_release,
  output logic             any_press
);

  logic [0:N_PAD-1] press_next;
  logic             any_press_q, any_press_d;

  generate
    for (genvar i = 0; i < N_PAD; i++) begin : g_ch
      pad_debounce_ch #(
        .DB_CYCLES     (DB_CYCLES)
`ifdef PAD_DEBOUNCE_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
      ) u_ch (
        .clk         (clk),
        .rst         (rst),
        .pad_raw     (pad_raw[i]),
        .pad_level   (pad_level[i]),
        .pad_press   (pad_press[i]),
        .pad_release (pad_release[i]),
        .press_next  (press_next[i])
      );
    end
  endgenerate

  // Built from next-state press so it lands in the same cycle as pad_press.
  always_comb begin
    any_press_d = |press_next;
  end

  always_ff @(posedge clk) begin
    if (rst) any_press_q <= 1'b0;
    else     any_press_q <= any_press_d;
  end

  assign any_press = any_press_q;

endmodule
`default_nettype wire

// File: tb/tb_pad_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pad_debounce : scoreboard bench for pad_debounce (DB_CYCLES=4)    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pad_debounce;
  import pad_pkg::*;

  localparam int NP   = 3;
  localparam int DB   = DB_CYCLES_SIM;
  localparam int LAT  = DB + 2;
  localparam int HOLD = 30;
`ifdef PAD_DEBOUNCE_AUTO_REPEAT_EN
  localparam int RD = 8;
  localparam int RP = 3;
`endif

  typedef struct packed {
    logic [0:NP-1] lvl;
    logic [0:NP-1] prs;
    logic [0:NP-1] rel;
    logic          any;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [0:NP-1] pad_raw = '0;
  logic [0:NP-1] pad_level;
  logic [0:NP-1] pad_press;
  logic [0:NP-1] pad_release;
  logic          any_press;

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pad_debounce #(
    .N_PAD         (NP),
    .DB_CYCLES     (DB)
`ifdef PAD_DEBOUNCE_AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pad_raw     (pad_raw),
    .pad_level   (pad_level),
    .pad_press   (pad_press),
    .pad_release (pad_release),
    .any_press   (any_press)
  );

  // Auto-repeat expectation; the pad is still seen high for 2 sync cycles after raw drops.
  function automatic logic [0:NP-1] exp_press_ar(int k);
    logic [0:NP-1] p;
    p = '0;
    if (k == LAT) p = 3'b100;
`ifdef PAD_DEBOUNCE_AUTO_REPEAT_EN
    if (k >= LAT + RD && k <= HOLD + 2 && ((k - LAT - RD) % RP) == 0) p = 3'b100;
`endif
    return p;
  endfunction

  task automatic test_reset();
    obs_t got, exp;
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      pad_raw = 3'b111;
      sb.push_back('{lvl: 3'b000, prs: 3'b000, rel: 3'b000, any: 1'b0});
      @(posedge clk); #1;
      got = {pad_level, pad_press, pad_release, any_press};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset cyc=%0d actual=%b required=%b", k, got, exp);
      end
    end
    for (int k = 1; k <= 8; k++) begin
      rst     = 1'b0;
      pad_raw = 3'b000;
      sb.push_back('{lvl: 3'b000, prs: 3'b000, rel: 3'b000, any: 1'b0});
      @(posedge clk); #1;
      got = {pad_level, pad_press, pad_release, any_press};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d actual=%b required=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    obs_t got, exp;
    for (int k = 1; k <= 20; k++) begin
      pad_raw = 3'b100;
      sb.push_back('{lvl: (k >= LAT) ? 3'b100 : 3'b000, prs: (k == LAT) ? 3'b100 : 3'b000,
                     rel: 3'b000, any: (k == LAT)});
      @(posedge clk); #1;
      got = {pad_level, pad_press, pad_release, any_press};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clean_press cyc=%0d actual=%b required=%b", k, got, exp);
      end
    end
  endtask

  // Single-cycle glitches, then a DB-1 cycle pulse: none may be accepted.
  task automatic test_bounce();
    obs_t got, exp;
    logic b;
    for (int k = 1; k <= 20; k++) begin
      b       = (k == 1) || (k == 3) || (k >= 8 && k <= 7 + DB - 1);
      pad_raw = {1'b1, b, 1'b0};
      sb.push_back('{lvl: 3'b100, prs: 3'b000, rel: 3'b000, any: 1'b0});
      @(posedge clk); #1;
      got = {pad_level, pad_press, pad_release, any_press};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bounce cyc=%0d actual=%b required=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_release();
    obs_t got, exp;
    for (int k = 1; k <= 12; k++) begin
      pad_raw = 3'b000;
      sb.push_back('{lvl: (k >= LAT) ? 3'b000 : 3'b100, prs: 3'b000,
                     rel: (k == LAT) ? 3'b100 : 3'b000, any: 1'b0});
      @(posedge clk); #1;
      got = {pad_level, pad_press, pad_release, any_press};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL release cyc=%0d actual=%b required=%b", k, got, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    obs_t got, exp;
    for (int k = 1; k <= 24; k++) begin
      pad_raw = (k <= 12) ? 3'b101 : 3'b000;
      sb.push_back('{lvl: (k >= LAT && k < 12 + LAT) ? 3'b101 : 3'b000,
                     prs: (k == LAT) ? 3'b101 : 3'b000,
                     rel: (k == 12 + LAT) ? 3'b101 : 3'b000,
                     any: (k == LAT)});
      @(posedge clk); #1;
      got = {pad_level, pad_press, pad_release, any_press};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL simultaneous cyc=%0d actual=%b required=%b", k, got, exp);
      end
    end
  endtask

  // rst pulse at E+3 discards progress; acceptance moves to E+3+LAT.
  task automatic test_reset_mid_count();
    obs_t got, exp;
    for (int k = 1; k <= 26; k++) begin
      pad_raw = (k <= 14) ? 3'b001 : 3'b000;
      rst     = (k == 3);
      sb.push_back('{lvl: (k >= 3 + LAT && k < 14 + LAT) ? 3'b001 : 3'b000,
                     prs: (k == 3 + LAT) ? 3'b001 : 3'b000,
                     rel: (k == 14 + LAT) ? 3'b001 : 3'b000,
                     any: (k == 3 + LAT)});
      @(posedge clk); #1;
      got = {pad_level, pad_press, pad_release, any_press};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d actual=%b required=%b", k, got, exp);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_auto_repeat();
    obs_t got, exp;
    logic [0:NP-1] p;
    for (int k = 1; k <= HOLD + 14; k++) begin
      pad_raw = (k <= HOLD) ? 3'b100 : 3'b000;
      p       = exp_press_ar(k);
      sb.push_back('{lvl: (k >= LAT && k < HOLD + LAT) ? 3'b100 : 3'b000, prs: p,
                     rel: (k == HOLD + LAT) ? 3'b100 : 3'b000, any: |p});
      @(posedge clk); #1;
      got = {pad_level, pad_press, pad_release, any_press};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL auto_repeat cyc=%0d actual=%b required=%b", k, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid_count();
    test_auto_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pad_debounce.md
Name: pad_debounce

Overview:
- Conditioning stage directly upstream of pad_counter; takes the raw, asynchronous, bouncing keypad lines and produces clean per-pad levels plus single-cycle press/release pulses.
- pad_counter consumes pad_level (same 3-bit MSB-first [0:2] ordering) and may use pad_press for edge-based counting.
- Per-channel: 2-flop synchronizer, then a stability counter and a 4-state FSM.

Parameters:
- N_PAD, 3, number of pad channels.
- DB_CYCLES, 500000, consecutive stable cycles required to accept a new level (5 ms at 100 MHz); benches override to 4. Legal range 2..2^20.
- CNT_W, $clog2(DB_CYCLES+1), stability counter width (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- pad_raw  in  [0:N_PAD-1]  raw asynchronous pad inputs, index 0 = leftmost pad.
- pad_level  out  [0:N_PAD-1]  debounced level, registered.
- pad_press  out  [0:N_PAD-1]  one-cycle pulse on accepted 0->1.
- pad_release  out  [0:N_PAD-1]  one-cycle pulse on accepted 1->0.
- any_press  out  1  OR of pad_press, registered together with it.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs registered.
- Reset: sync flops, counters, pad_level, pad_press, pad_release and any_press all clear to 0; FSM = LOW. rst overrides all other activity in the same cycle. Reset mid-count discards progress. A pad held high through reset is accepted DB_CYCLES+2 cycles after rst deasserts, with a press pulse.
- Synchronizer: s1 <= pad_raw; s2 <= s1. Only s2 feeds the FSM.
- FSM per channel:
  - LOW: if s2 = 1, go to RISE with cnt = 1.
  - RISE: if s2 = 0, go to LOW with cnt = 0 (bounce rejected, no pulse).
  - RISE: else if cnt = DB_CYCLES-1, go to HIGH with pad_level <= 1 and pad_press <= 1 for exactly one cycle.
  - RISE: else cnt++.
  - HIGH and FALL mirror LOW and RISE for s2 = 0, producing pad_release on the accepted 1->0.
- Latency: raw held stable from sampling edge E. pad_level and pulse are visible after edge E + DB_CYCLES + 2. A level held for fewer than DB_CYCLES cycles at s2 is never accepted.
- Counter saturates by construction (reset on state change); no wrap-around possible.
- Channels are fully independent. Simultaneous presses give simultaneous pulses, and any_press = 1 for that single cycle.
- press and release on the same channel are mutually exclusive in any cycle. Minimum spacing between them is DB_CYCLES cycles.

Optional Feature:
- Macro: PAD_DEBOUNCE_AUTO_REPEAT_EN.
- Defined: adds parameters REPEAT_DELAY (default 50000000) and REPEAT_PERIOD (default 10000000). In HIGH, a repeat counter starts at the accept edge. The first extra pad_press fires REPEAT_DELAY cycles after the accepted press, then one every REPEAT_PERIOD cycles until the channel leaves HIGH. Entering FALL freezes the repeat counter; returning to HIGH resumes it; reaching LOW clears it. Repeat pulses also drive any_press.
- Undefined: no repeat logic or parameters are synthesized; exactly one pad_press per accepted press.

Decomposition:
- Package pad_pkg: N_PAD default, state encoding constants (LOW=2'b00, RISE=2'b01, HIGH=2'b10, FALL=2'b11), DB_CYCLES sim/board defaults.
- Sub-module pad_debounce_ch: one channel (sync + FSM + counter + optional repeat).
- pad_debounce: instantiates N_PAD of them via generate and ORs any_press.

Test Plan (DB_CYCLES=4; REPEAT_DELAY=8, REPEAT_PERIOD=3 when macro defined):
- Clean press: raw[0] 0->1 held 20 cycles -> pad_level[0]=1 and pad_press=3'b100 exactly one cycle at E+6; no other pulses.
- Bounce reject: raw[1] toggles 1,0,1,0 each cycle then stays 0 -> pad_level, pad_press and pad_release stay 3'b000 throughout.
- Release: after accepted press, raw[0] -> 0 held -> pad_release=3'b100 one cycle at E+6; pad_level[0]=0.
- Simultaneous: raw=3'b101 in one cycle -> pad_press=3'b101 and any_press=1 in the same single cycle.
- Reset mid-count: raw[2]=1, assert rst at E+3 for 1 cycle while raw stays 1 -> all outputs 0 during reset; press accepted 6 cycles after rst deasserts.
- Auto-repeat (macro defined): hold raw[0] 30 cycles -> pad_press[0] at E+6, E+14, E+17, E+20, ...; no repeats after release. Macro undefined: single pulse only.
